// File: rtl/systolic_sched.sv
// systolic_sched: row sequencer for the 2x2 triangular Givens-rotation array
module systolic_sched #(
    parameter int DW    = 32,
    parameter int CW    = 8,
    parameter int DRAIN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_rows,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x1,
    input  logic [DW-1:0] in_x2,
    output logic [DW-1:0] arr_x01,
    output logic [DW-1:0] arr_x02,
    output logic          arr_clr,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] row_cnt
);
    localparam int DCW = DRAIN > 1 ? $clog2(DRAIN) : 1;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] DRN   = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]     state;
    logic [CW-1:0]  num_q;
    logic [DCW-1:0] dcnt;
    logic [DW-1:0]  skew;
    logic           acc;

    assign in_ready = state == FEED;
    assign arr_clr  = state == CLEAR;
    assign done     = state == FIN;
    assign busy     = state != IDLE;
    assign acc      = in_valid && in_ready;

    // job control: clear, feed rows, drain the skew and pe_22 stage, pulse done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            num_q   <= '0;
            row_cnt <= '0;
            dcnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (num_rows != '0) begin
                        num_q   <= num_rows;
                        row_cnt <= '0;
                        state   <= CLEAR;
                    end else begin
                        state <= FIN;
                    end
                end
                CLEAR: state <= FEED;
                FEED: if (acc) begin
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt + 1'b1 == num_q) begin
                        state <= DRN;
                        dcnt  <= DCW'(DRAIN - 1);
                    end
                end
                DRN: if (dcnt == '0) state <= FIN; else dcnt <= dcnt - 1'b1;
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // array inputs: x1 goes straight out, x2 waits one cycle in skew; bubbles are zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_x01 <= '0;
            skew    <= '0;
            arr_x02 <= '0;
        end else if (state == CLEAR) begin
            arr_x01 <= '0;
            skew    <= '0;
            arr_x02 <= '0;
        end else begin
            arr_x01 <= acc ? in_x1 : '0;
            skew    <= acc ? in_x2 : '0;
            arr_x02 <= skew;
        end
    end
endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched: scoreboard bench for the Givens-array row sequencer
module tb_systolic_sched;
    logic        clk = 0, rst = 0, start = 0, in_valid = 0;
    logic [3:0]  num_rows = 0;
    logic [31:0] in_x1 = 0, in_x2 = 0;
    logic        in_ready, arr_clr, busy, done;
    logic [31:0] arr_x01, arr_x02;
    logic [3:0]  row_cnt;

    systolic_sched #(.DW(32), .CW(4), .DRAIN(2)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
        .arr_x01(arr_x01), .arr_x02(arr_x02), .arr_clr(arr_clr),
        .busy(busy), .done(done), .row_cnt(row_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, clr_cnt = 0, nz = 0;
    logic        mon = 0, pend = 0;
    logic [31:0] pend_x2 = 0;
    logic [63:0] q[$];

    // single comparison point: counts and reports mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // advance one clock and observe outputs at the following falling edge
    task automatic step();
        logic [63:0] e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (mon) begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (arr_clr) clr_cnt++;
            chk("x02", arr_x02, pend ? pend_x2 : 32'd0);
            pend = 0;
            if (arr_x01 != 0) begin
                nz++;
                if (q.size() == 0) chk("x01_extra", arr_x01, 0);
                else begin
                    e = q.pop_front();
                    chk("x01", arr_x01, e[63:32]);
                    pend = 1;
                    pend_x2 = e[31:0];
                end
            end
        end
    endtask

    // offer a row until it is accepted; in_valid stays high afterwards
    task automatic send_row(input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 0;
        in_valid = 1; in_x1 = a; in_x2 = b;
        for (int i = 0; i < 20 && !got; i++) begin
            if (in_ready) begin
                q.push_back({a, b});
                acc_cyc = cyc;
                got = 1;
            end
            step();
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int lat);
        int d0;
        d0 = done_cnt;
        in_valid = 0;
        for (int i = 0; i < 20 && done_cnt == d0; i++) step();
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        else chk("done_lat", done_cyc - acc_cyc, lat);
    endtask

    task automatic begin_job(input logic [3:0] n);
        num_rows = n; start = 1;
        step();
        start = 0;
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_clr", arr_clr, 0);
        chk("rst_x01", arr_x01, 0);
        chk("rst_x02", arr_x02, 0);
        chk("rst_cnt", row_cnt, 0);
        @(negedge clk);
        rst = 1;
        step();
        mon = 1;

        // basic job, valid held high
        clr_cnt = 0; done_cnt = 0;
        begin_job(3);
        chk("b_clr", arr_clr, 1);
        chk("b_busy", busy, 1);
        send_row(1, 2);
        send_row(3, 4);
        send_row(5, 6);
        chk("b_x01_last", arr_x01, 5);
        chk("b_x02_last", arr_x02, 4);
        wait_done(3);
        chk("b_rows", row_cnt, 3);
        chk("b_clr_cnt", clr_cnt, 1);
        chk("b_q_empty", q.size(), 0);
        step();
        chk("b_idle", busy, 0);

        // stalled rows
        begin_job(2);
        send_row(7, 8);
        in_valid = 0;
        step();
        chk("s_bubble", arr_x01, 0);
        step();
        send_row(9, 10);
        wait_done(3);
        chk("s_rows", row_cnt, 2);
        chk("s_q_empty", q.size(), 0);
        step();

        // zero-length job
        clr_cnt = 0; done_cnt = 0;
        begin_job(0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 1);
        chk("z_ready", in_ready, 0);
        step();
        chk("z_done_off", done, 0);
        chk("z_busy_off", busy, 0);
        chk("z_clr_cnt", clr_cnt, 0);
        chk("z_done_cnt", done_cnt, 1);

        // start held through a job, then back-to-back job
        clr_cnt = 0; done_cnt = 0;
        num_rows = 1; start = 1;
        step();
        send_row(11, 12);
        wait_done(3);
        chk("bb_clr_cnt", clr_cnt, 1);
        chk("bb_done_cnt", done_cnt, 1);
        num_rows = 2;
        step();
        chk("bb_idle", busy, 0);
        chk("bb_hold_cnt", row_cnt, 1);
        step();
        start = 0;
        chk("bb_clr2", arr_clr, 1);
        chk("bb_cnt0", row_cnt, 0);
        send_row(13, 14);
        send_row(15, 16);
        wait_done(3);
        chk("bb_rows", row_cnt, 2);
        chk("bb_done_cnt2", done_cnt, 2);
        step();

        // maximum row count
        done_cnt = 0; nz = 0;
        begin_job(15);
        for (int i = 1; i <= 15; i++) send_row(i, i + 100);
        wait_done(3);
        for (int i = 0; i < 3; i++) step();
        chk("m_rows", row_cnt, 15);
        chk("m_nz", nz, 15);
        chk("m_done_cnt", done_cnt, 1);
        chk("m_q_empty", q.size(), 0);

        // asynchronous reset in the middle of feeding
        done_cnt = 0;
        begin_job(4);
        send_row(21, 22);
        send_row(23, 24);
        in_valid = 0;
        #2;
        mon = 0;
        rst = 0;
        #1;
        chk("r_x01", arr_x01, 0);
        chk("r_x02", arr_x02, 0);
        chk("r_busy", busy, 0);
        chk("r_ready", in_ready, 0);
        chk("r_cnt", row_cnt, 0);
        q.delete();
        pend = 0;
        step();
        rst = 1;
        mon = 1;
        for (int i = 0; i < 5; i++) step();
        chk("r_idle", busy, 0);
        chk("r_no_done", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/systolic_sched.md
Name: systolic_sched

Overview:
- Sequencer for the 2x2 triangular Givens-rotation array: boundary cells pe_11/pe_22, internal cell pe_12.
- Accepts matrix rows over a valid/ready stream and issues a one-cycle array clear before each job.
- Drives x01 directly and x02 one cycle later, so pe_12 sees each row's c/s from pe_11.
- Inserts zero bubbles while stalled, drains the pipeline, and pulses done. Sits between the row source and the array top.

Parameters:
- DW, 32, data width of x01/x02 and input row elements.
- CW, 8, width of the row counter and num_rows.
- DRAIN, 2, bubble cycles after the last row (1 skew + 1 pe_22 stage).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin job; sampled only in IDLE.
- num_rows  in  CW  rows in job; captured on start.
- in_valid  in  1  row valid.
- in_ready  out  1  row accepted when in_valid && in_ready.
- in_x1  in  DW  row element, column 1.
- in_x2  in  DW  row element, column 2.
- arr_x01  out  DW  array input x01, registered.
- arr_x02  out  DW  array input x02, registered, skewed +1 cycle.
- arr_clr  out  1  one-cycle array clear; the top maps it onto the array reset.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- row_cnt  out  CW  rows accepted in the current job.

Behaviour:
- Reset (rst=0, async) forces: state IDLE; arr_x01=0, arr_x02=0, skew register=0; arr_clr=0, done=0, busy=0, in_ready=0; row_cnt=0, drain counter=0. This applies mid-job too; the partial job is abandoned with no done pulse.
- FSM states: IDLE, CLEAR, FEED, DRAIN, FIN.
- IDLE, start=1, num_rows!=0: capture num_rows, clear row_cnt, go to CLEAR.
- IDLE, start=1, num_rows==0: go to FIN. No clear, no data.
- start outside IDLE is ignored.
- CLEAR: arr_clr=1 for exactly this one cycle; arr_x01/arr_x02/skew register forced to 0; next state FEED.
- FEED, in_ready: in_ready=1 combinationally in FEED only.
- FEED, accept: arr_x01 <= in_x1, skew <= in_x2, arr_x02 <= skew, row_cnt++.
- FEED, no accept: arr_x01 <= 0, skew <= 0, arr_x02 <= skew. Zero is a bubble; the skew still advances, so each x2 reaches arr_x02 exactly 1 cycle after its x1 reaches arr_x01.
- FEED, last row: on the accept that makes row_cnt == num_rows, go to DRAIN and load the drain counter with DRAIN-1.
- DRAIN: in_ready=0; bubbles as above; counter decrements; at 0, go to FIN.
- FIN: done=1 for one cycle, busy still 1; next state IDLE.
- row_cnt holds its value in IDLE until the next accepted start.
- Row latency: in_x1 appears on arr_x01 1 cycle after accept; in_x2 appears on arr_x02 2 cycles after accept.
- done latency: fires DRAIN+1 cycles after the last accept (DRAIN cycles in DRAIN, then FIN).
- Back-to-back jobs: a start asserted in the cycle after FIN is taken normally. Each job gets its own CLEAR, so no state carries over between jobs.
- num_rows = 2^CW-1 is supported; row_cnt never wraps within a job.
- in_valid outside FEED is ignored (in_ready=0); no data is lost.

Test Plan:
- Reset mid-FEED: after 2 of 4 rows, drop rst -> all outputs 0 at once; after release, IDLE with busy=0 and no done pulse.
- Basic job: num_rows=3, rows (1,2),(3,4),(5,6) with in_valid held high -> arr_clr pulses once. arr_x01 = 1,3,5,0,0 on consecutive cycles; arr_x02 = 0,2,4,6,0 aligned with them. done pulses 3 cycles after the 3rd accept; row_cnt=3.
- Stalls: num_rows=2, in_valid pattern 1,0,0,1 with rows (7,8),(9,10) -> arr_x01 = 7,0,0,9; arr_x02 lags by exactly 1 cycle (8 and 10); done 3 cycles after 2nd accept.
- Zero-length: start with num_rows=0 -> no arr_clr, in_ready never 1; done pulses 1 cycle after start; busy high for that 1 cycle.
- Ignored start and back-to-back: start held high throughout a num_rows=1 job -> no restart mid-job; a 2nd job begins in the cycle after done, with a fresh arr_clr and row_cnt restarting from 0.
- Max count: CW=4, num_rows=15, continuous valid -> row_cnt reaches 15 with no wrap; exactly 15 nonzero values on arr_x01; one done pulse.
